stop_count_capture: RTL and testbench
=====================================

Name: stop_count_capture

Overview:
- Sits directly downstream of the timing FPGA stop logic, in the same clk_tf domain.
- Consumes the stop_tos_count pulse burst (one pulse per slow-clock tick between top-of-second and the raw PPS edge) and the tos_mark_ddc one-cycle top-of-second marker.
- Rebuilds each burst into a binary coarse-offset count, tags it with a second sequence number and error flags, and presents one record per second on a valid/ready interface to the uC-side register bank.

Parameters:
- CountWidth, 14, width of the coarse count (covers 10000 slow clocks per second).
- SeqWidth, 8, width of the second sequence tag; wraps modulo 2^SeqWidth.
- GapCycles, 8, idle clk_tf cycles with no rising edge that end a burst; must be >= 3 because pulses arrive every 2 cycles.

Ports:
- clk_tf  in  1  19.2 MHz timing clock.
- tf_reset  in  1  Reset: synchronous, active-high.
- stop_tos_count  in  1  Pulse train; high 1 cycle, low 1 cycle per count.
- tos_mark  in  1  One-cycle marker; the next clk_tf rising edge is the top of second.
- rec_ready  in  1  Consumer accepts the record when rec_valid && rec_ready.
- rec_valid  out  1  Record available.
- rec_count  out  CountWidth  Number of pulses in the burst.
- rec_seq  out  SeqWidth  Sequence number of the second in which the burst started.
- rec_saturated  out  1  Burst exceeded 2^CountWidth-1 pulses.
- rec_framing_err  out  1  A tos_mark arrived while the burst was still running.
- rec_missing  out  1  A full second elapsed with no burst; rec_count = 0.
- rec_overrun  out  1  The previous unaccepted record was overwritten.

Behaviour:
- Reset: all outputs 0, state S_IDLE, seq = 0, armed = 0, seen = 0, counters = 0. Reset asserted mid-burst discards the burst and publishes nothing.
- Edge detect: rise = stop_tos_count && !stop_d1, with stop_d1 a registered copy of the input.
- States:
  - S_IDLE: on rise, go to S_BURST, count = 1, gap = 0, latch burst_seq = seq (or seq+1 if tos_mark is in the same cycle).
  - S_BURST: on rise, count increments (saturating at all-ones and setting sat) and gap = 0. Otherwise gap increments. When gap == GapCycles-1 with no rise: publish, set seen = 1, go to S_IDLE.
- tos_mark handling:
  - seq increments and armed is set to 1.
  - In S_BURST: publish immediately with framing_err = 1 and the count so far. If a rise occurs in the same cycle, it starts a new burst (count = 1) tagged with the new seq.
  - In S_IDLE with armed && !seen: publish a missing record (count 0, seq = old seq).
  - seen clears on every tos_mark.
- tos_mark in the same cycle as gap expiry: publish a normal record only. The tos_mark still increments seq and clears seen. No missing record is generated.
- Publish timing: the record registers load at the clock edge, so rec_valid is high starting the next cycle. For the last rise sampled in cycle k, rec_valid rises in cycle k+GapCycles.
- Handshake:
  - rec_valid stays high and the outputs stay stable until accepted.
  - Acceptance with no publish in the same cycle: rec_valid drops the next cycle.
  - Publish while rec_valid && !rec_ready: the new record overwrites the old one with rec_overrun = 1.
  - Publish in the same cycle as acceptance: the new record loads with rec_overrun = 0.
- At most one publish per cycle; the cases above are mutually exclusive by construction.

Decomposition:
- Shared package timing_pkg holds:
  - the stop_rec_t struct (count, seq, saturated, framing_err, missing, overrun);
  - the capture state enum (S_IDLE, S_BURST);
  - constants SlowClocksPerSecond and the default CountWidth.
- One natural sub-module, pulse_burst_counter: edge detect, gap timer and saturating count, with a burst_done/count/sat output.
- The top level holds the second/seq bookkeeping and the output holding register.

Test Plan:
- 5 pulses at period 2, rec_ready = 1 → a single record: count 5, flags 0, rec_valid high exactly GapCycles cycles after the 5th rise.
- tos_mark, 20 M idle cycles, tos_mark with no pulses → a missing record: count 0, seq = 1, rec_missing = 1.
- Burst of 12 pulses with tos_mark after the 6th rise, and a rise in the same cycle as the tos_mark → a framing record (count 6, framing_err = 1), then a count-6 record with seq+1.
- 2^CountWidth+3 pulses → count = 16383, rec_saturated = 1.
- Two bursts with rec_ready = 0 → the second record is held with rec_overrun = 1. Repeat with rec_ready pulsed in the publish cycle → rec_overrun = 0.
- tf_reset asserted after the 3rd pulse, then 4 clean pulses → one record: count 4, seq = 0, no flags.

Source files
------------

// File: rtl/timing_pkg.sv
// ---------------------------------------------------------------------------
// timing_pkg
// Shared types and constants for the clk_tf-domain stop/top-of-second logic.
//   SlowClocksPerSecond : slow-clock ticks in one second
//   DefCountWidth       : coarse count width that covers one second of ticks
//   DefSeqWidth         : default width of the per-second sequence tag
//   DefGapCycles        : idle clk_tf cycles that terminate a pulse burst
//   cap_state_e         : burst capture state (S_IDLE / S_BURST)
//   stop_rec_t          : one published record, default-width view used by the
//                         uC-side register bank
// ---------------------------------------------------------------------------
package timing_pkg;

    localparam int SlowClocksPerSecond = 10000;
    localparam int DefCountWidth       = $clog2(SlowClocksPerSecond);
    localparam int DefSeqWidth         = 8;
    localparam int DefGapCycles        = 8;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } cap_state_e;

    typedef struct packed {
        logic [DefCountWidth-1:0] count;
        logic [DefSeqWidth-1:0]   seq;
        logic                     saturated;
        logic                     framing_err;
        logic                     missing;
        logic                     overrun;
    } stop_rec_t;

endpackage : timing_pkg

// File: rtl/pulse_burst_counter.sv
// ---------------------------------------------------------------------------
// pulse_burst_counter
// Turns the stop_tos_count pulse train into a binary burst length.
//   clk_i        : clk_tf
//   rst_i        : synchronous active-high reset
//   stop_i       : raw pulse train (1 cycle high, >= 1 cycle low per count)
//   cut_i        : end the running burst now (top-of-second inside a burst);
//                  a rise in the same cycle starts a fresh burst
//   rise_o       : rising edge of stop_i this cycle
//   busy_o       : a burst is being counted (state S_BURST)
//   burst_done_o : gap timer expired this cycle; count_o/sat_o hold the result
//   count_o      : pulses counted so far in the current burst (saturating)
//   sat_o        : a rise was seen while the count was already all-ones
// ---------------------------------------------------------------------------
module pulse_burst_counter
    import timing_pkg::*;
#(
    parameter int CountWidth = DefCountWidth,
    // Pulses arrive every 2 cycles, so GapCycles must be at least 3.
    parameter int GapCycles  = DefGapCycles
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  stop_i,
    input  logic                  cut_i,
    output logic                  rise_o,
    output logic                  busy_o,
    output logic                  burst_done_o,
    output logic [CountWidth-1:0] count_o,
    output logic                  sat_o
);

    localparam int              GapW    = (GapCycles > 2) ? $clog2(GapCycles) : 2;
    localparam logic [GapW-1:0] GapLast = GapW'(GapCycles - 1);

    cap_state_e            state_q, state_d;
    logic                  stop_d1_q;
    logic [GapW-1:0]       gap_q, gap_d;
    logic [GapW-1:0]       gap_inc;
    logic [CountWidth-1:0] count_q, count_d;
    logic                  sat_q, sat_d;
    logic                  rise;

    assign rise    = stop_i && !stop_d1_q;
    // The idle-cycle count including the current cycle; compared against
    // GapLast so the result is registered GapCycles cycles after the last rise.
    assign gap_inc = gap_q + GapW'(1);

    assign rise_o       = rise;
    assign busy_o       = (state_q == S_BURST);
    assign burst_done_o = (state_q == S_BURST) && !rise && (gap_inc == GapLast);
    assign count_o      = count_q;
    assign sat_o        = sat_q;

    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        count_d = count_q;
        sat_d   = sat_q;
        unique case (state_q)
            S_IDLE: begin
                if (rise) begin
                    state_d = S_BURST;
                    count_d = CountWidth'(1);
                    sat_d   = 1'b0;
                    gap_d   = '0;
                end
            end
            S_BURST: begin
                if (cut_i) begin
                    // The cut burst was already reported by the top; the
                    // coincident rise belongs to the next second.
                    if (rise) begin
                        count_d = CountWidth'(1);
                        sat_d   = 1'b0;
                        gap_d   = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else if (rise) begin
                    gap_d = '0;
                    if (count_q == '1) begin
                        sat_d = 1'b1;
                    end else begin
                        count_d = count_q + CountWidth'(1);
                    end
                end else if (gap_inc == GapLast) begin
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_inc;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            stop_d1_q <= 1'b0;
            gap_q     <= '0;
            count_q   <= '0;
            sat_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            stop_d1_q <= stop_i;
            gap_q     <= gap_d;
            count_q   <= count_d;
            sat_q     <= sat_d;
        end
    end

endmodule : pulse_burst_counter

// File: rtl/stop_count_capture.sv
// ---------------------------------------------------------------------------
// stop_count_capture
// Rebuilds each stop_tos_count burst into a coarse-offset count, tags it with
// the sequence number of the second it started in plus error flags, and holds
// one record at a time for the uC-side register bank.
//   clk_tf_i            : 19.2 MHz timing clock
//   tf_reset_i          : synchronous active-high reset
//   stop_tos_count_i    : pulse train, one pulse per slow-clock tick
//   tos_mark_i          : one-cycle marker, next edge is top of second
//   rec_ready_i         : consumer takes the record when valid && ready
//   rec_valid_o         : record available, held stable until accepted
//   rec_count_o         : pulses in the burst (0 for a missing record)
//   rec_seq_o           : second sequence tag
//   rec_saturated_o     : burst longer than the count can express
//   rec_framing_err_o   : top of second arrived while the burst was running
//   rec_missing_o       : a whole second passed with no burst
//   rec_overrun_o       : an unaccepted record was overwritten by this one
// ---------------------------------------------------------------------------
module stop_count_capture
    import timing_pkg::*;
#(
    parameter int CountWidth = DefCountWidth,
    parameter int SeqWidth   = DefSeqWidth,
    parameter int GapCycles  = DefGapCycles
) (
    input  logic                  clk_tf_i,
    input  logic                  tf_reset_i,
    input  logic                  stop_tos_count_i,
    input  logic                  tos_mark_i,
    input  logic                  rec_ready_i,
    output logic                  rec_valid_o,
    output logic [CountWidth-1:0] rec_count_o,
    output logic [SeqWidth-1:0]   rec_seq_o,
    output logic                  rec_saturated_o,
    output logic                  rec_framing_err_o,
    output logic                  rec_missing_o,
    output logic                  rec_overrun_o
);

    // Same field layout as stop_rec_t, sized by this instance's parameters.
    typedef struct packed {
        logic [CountWidth-1:0] count;
        logic [SeqWidth-1:0]   seq;
        logic                  saturated;
        logic                  framing_err;
        logic                  missing;
        logic                  overrun;
    } rec_t;

    logic                  rise, busy, burst_done, burst_sat;
    logic [CountWidth-1:0] burst_count;
    logic                  cut, miss, publish, start;

    logic [SeqWidth-1:0]   seq_q, seq_d;
    logic [SeqWidth-1:0]   burst_seq_q, burst_seq_d;
    logic                  armed_q, armed_d;
    logic                  seen_q, seen_d;
    logic                  valid_q, valid_d;
    rec_t                  rec_q, rec_d;
    rec_t                  pub_rec;

    pulse_burst_counter #(
        .CountWidth (CountWidth),
        .GapCycles  (GapCycles)
    ) u_counter (
        .clk_i        (clk_tf_i),
        .rst_i        (tf_reset_i),
        .stop_i       (stop_tos_count_i),
        .cut_i        (cut),
        .rise_o       (rise),
        .busy_o       (busy),
        .burst_done_o (burst_done),
        .count_o      (burst_count),
        .sat_o        (burst_sat)
    );

    // Gap expiry wins over a coincident top-of-second: the burst had already
    // ended, so it is a normal record and no missing record is produced.
    assign cut     = tos_mark_i && busy && !burst_done;
    // Missing needs one full second observed: armed by an earlier tos_mark.
    assign miss    = tos_mark_i && !busy && armed_q && !seen_q;
    assign publish = burst_done || cut || miss;
    // A rise either opens a burst from idle or reopens one cut by tos_mark.
    assign start   = rise && (!busy || cut);

    always_comb begin
        pub_rec             = '0;
        pub_rec.count       = miss ? '0 : burst_count;
        pub_rec.seq         = miss ? seq_q : burst_seq_q;
        pub_rec.saturated   = !miss && burst_sat;
        pub_rec.framing_err = cut;
        pub_rec.missing     = miss;
        pub_rec.overrun     = valid_q && !rec_ready_i;
    end

    always_comb begin
        seq_d       = tos_mark_i ? seq_q + SeqWidth'(1) : seq_q;
        armed_d     = armed_q || tos_mark_i;
        seen_d      = seen_q;
        if (burst_done) seen_d = 1'b1;
        if (tos_mark_i) seen_d = 1'b0;
        // Tag with the post-increment seq so a burst starting on the top of
        // second belongs to the new second.
        burst_seq_d = start ? seq_d : burst_seq_q;
    end

    always_comb begin
        valid_d = valid_q;
        rec_d   = rec_q;
        if (publish) begin
            valid_d = 1'b1;
            rec_d   = pub_rec;
        end else if (valid_q && rec_ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_tf_i) begin
        if (tf_reset_i) begin
            seq_q       <= '0;
            burst_seq_q <= '0;
            armed_q     <= 1'b0;
            seen_q      <= 1'b0;
            valid_q     <= 1'b0;
            rec_q       <= '0;
        end else begin
            seq_q       <= seq_d;
            burst_seq_q <= burst_seq_d;
            armed_q     <= armed_d;
            seen_q      <= seen_d;
            valid_q     <= valid_d;
            rec_q       <= rec_d;
        end
    end

    assign rec_valid_o       = valid_q;
    assign rec_count_o       = rec_q.count;
    assign rec_seq_o         = rec_q.seq;
    assign rec_saturated_o   = rec_q.saturated;
    assign rec_framing_err_o = rec_q.framing_err;
    assign rec_missing_o     = rec_q.missing;
    assign rec_overrun_o     = rec_q.overrun;

endmodule : stop_count_capture

// File: tb/tb_stop_count_capture.sv
module tb_stop_count_capture;

    localparam int CW   = 14;
    localparam int SW   = 8;
    localparam int G    = 8;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1, stop = 1'b0, tos = 1'b0, ready = 1'b1;
    logic          valid, sat, fe, miss, ovr;
    logic [CW-1:0] cnt;
    logic [SW-1:0] seq;

    always #26 clk = ~clk;

    stop_count_capture #(.CountWidth(CW), .SeqWidth(SW), .GapCycles(G)) dut (
        .clk_tf_i          (clk),
        .tf_reset_i        (rst),
        .stop_tos_count_i  (stop),
        .tos_mark_i        (tos),
        .rec_ready_i       (ready),
        .rec_valid_o       (valid),
        .rec_count_o       (cnt),
        .rec_seq_o         (seq),
        .rec_saturated_o   (sat),
        .rec_framing_err_o (fe),
        .rec_missing_o     (miss),
        .rec_overrun_o     (ovr)
    );

    int n_checks = 0, n_fail = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Burst bookkeeping by timestamps and unbounded counts; the held record
    // follows the valid/ready rules directly.
    int m_cyc = 0, m_last = 0, m_cnt = 0, m_tag = 0, m_seq = 0;
    bit m_prev = 0, m_inb = 0, m_armed = 0, m_seen = 0;
    bit e_valid = 0, e_sat = 0, e_fe = 0, e_miss = 0, e_ovr = 0;
    int e_cnt = 0, e_seq = 0;

    task automatic model_step(input bit s, input bit t, input bit r, input bit rs);
        bit rise, pub, p_sat, p_fe, p_miss;
        int p_cnt, p_seq;
        if (rs) begin
            m_prev = 0; m_inb = 0; m_armed = 0; m_seen = 0; m_seq = 0; m_cnt = 0;
            e_valid = 0; e_cnt = 0; e_seq = 0; e_sat = 0; e_fe = 0; e_miss = 0; e_ovr = 0;
            m_cyc++;
            return;
        end
        rise = s && !m_prev;
        pub = 0; p_sat = 0; p_fe = 0; p_miss = 0; p_cnt = 0; p_seq = 0;
        if (m_inb && !rise && (m_cyc - m_last == G - 1)) begin
            pub = 1; p_cnt = (m_cnt > CMAX) ? CMAX : m_cnt; p_seq = m_tag;
            p_sat = (m_cnt > CMAX); m_inb = 0; m_seen = 1;
        end else if (t && m_inb) begin
            pub = 1; p_cnt = (m_cnt > CMAX) ? CMAX : m_cnt; p_seq = m_tag;
            p_sat = (m_cnt > CMAX); p_fe = 1; m_inb = 0;
        end else if (t && m_armed && !m_seen) begin
            pub = 1; p_cnt = 0; p_seq = m_seq; p_miss = 1;
        end
        if (t) begin
            m_seq = (m_seq + 1) % (1 << SW); m_armed = 1; m_seen = 0;
        end
        if (rise) begin
            if (m_inb) m_cnt++;
            else begin m_inb = 1; m_cnt = 1; m_tag = m_seq; end
            m_last = m_cyc;
        end
        if (pub) begin
            e_ovr = e_valid && !r; e_valid = 1; e_cnt = p_cnt; e_seq = p_seq;
            e_sat = p_sat; e_fe = p_fe; e_miss = p_miss;
        end else if (e_valid && r) begin
            e_valid = 0;
        end
        m_prev = s;
        m_cyc++;
    endtask

    // One clk_tf cycle: drive, advance the model, sample 1 time unit after the edge.
    task automatic tick(input bit s, input bit t, input bit r, input bit rs);
        stop = s; tos = t; ready = r; rst = rs;
        model_step(s, t, r, rs);
        @(posedge clk);
        #1;
        check("model_valid", valid, e_valid);
        if (e_valid) begin
            check("model_count", cnt, e_cnt);
            check("model_seq", seq, e_seq);
            check("model_sat", sat, e_sat);
            check("model_framing", fe, e_fe);
            check("model_missing", miss, e_miss);
            check("model_overrun", ovr, e_ovr);
        end
    endtask

    // n pulses at the given period; returns right after the last high cycle.
    task automatic send(input int n, input int per, input bit r);
        for (int i = 0; i < n; i++) begin
            tick(1, 0, r, 0);
            if (i != n - 1) repeat (per - 1) tick(0, 0, r, 0);
        end
    endtask

    task automatic wait_rec(input bit r, output int waited);
        waited = 0;
        while (!valid && waited < 40) begin
            tick(0, 0, r, 0);
            waited++;
        end
        if (!valid) check("wait_rec_timeout", 0, 1);
    endtask

    task automatic expect_rec(input string nm, input int c, input int sq,
                              input bit s_, input bit f_, input bit m_, input bit o_);
        check({nm, "_valid"}, valid, 1);
        check({nm, "_count"}, cnt, c);
        check({nm, "_seq"}, seq, sq);
        check({nm, "_sat"}, sat, s_);
        check({nm, "_framing"}, fe, f_);
        check({nm, "_missing"}, miss, m_);
        check({nm, "_overrun"}, ovr, o_);
    endtask

    typedef struct {
        int n;
        int per;
        int exp_cnt;
        int exp_wait;
    } vec_t;

    initial begin
        #(100000 * 52);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[4];
        int   w;
        int   dens;
        int   p;
        bit   s, t, r, rs;
        tbl[0] = '{5, 2, 5, G - 1};
        tbl[1] = '{1, 2, 1, G - 1};
        tbl[2] = '{9, 3, 9, G - 1};
        tbl[3] = '{40, 2, 40, G - 1};

        // Reset state
        tick(0, 0, 1, 1);
        tick(0, 0, 1, 1);
        check("reset_valid", valid, 0);
        check("reset_count", cnt, 0);
        check("reset_seq", seq, 0);
        check("reset_flags", {sat, fe, miss, ovr}, 0);
        tick(0, 0, 1, 0);

        // Plain bursts: count and publish latency after the last rise
        foreach (tbl[i]) begin
            send(tbl[i].n, tbl[i].per, 1);
            wait_rec(1, w);
            check("tbl_wait", w, tbl[i].exp_wait);
            expect_rec("tbl", tbl[i].exp_cnt, 0, 0, 0, 0, 0);
            tick(0, 0, 1, 0);
            check("tbl_accept_drop", valid, 0);
            repeat (3) tick(0, 0, 1, 0);
        end

        // Missing second: the first mark only arms
        tick(0, 1, 1, 0);
        check("miss_first_mark", valid, 0);
        repeat (5) tick(0, 0, 1, 0);
        tick(0, 1, 1, 0);
        expect_rec("missing", 0, 1, 0, 0, 1, 0);
        tick(0, 0, 1, 0);

        // Framing: mark coincides with the 7th rise of a 12-pulse train
        send(6, 2, 1);
        tick(0, 0, 1, 0);
        tick(1, 1, 1, 0);
        expect_rec("framing", 6, 2, 0, 1, 0, 0);
        tick(0, 0, 1, 0);
        send(5, 2, 1);
        wait_rec(1, w);
        expect_rec("after_framing", 6, 3, 0, 0, 0, 0);
        tick(0, 0, 1, 0);

        // Saturation
        send(CMAX + 4, 2, 1);
        wait_rec(1, w);
        expect_rec("saturate", CMAX, 3, 1, 0, 0, 0);
        tick(0, 0, 1, 0);

        // Overrun: second record overwrites an unaccepted one
        send(3, 2, 0);
        wait_rec(0, w);
        expect_rec("ovr_first", 3, 3, 0, 0, 0, 0);
        send(2, 2, 0);
        repeat (G - 1) tick(0, 0, 0, 0);
        expect_rec("ovr_second", 2, 3, 0, 0, 0, 1);
        tick(0, 0, 1, 0);
        check("ovr_accept_drop", valid, 0);

        // Acceptance in the publish cycle: no overrun
        send(3, 2, 0);
        wait_rec(0, w);
        send(2, 2, 0);
        repeat (G - 2) tick(0, 0, 0, 0);
        tick(0, 0, 1, 0);
        expect_rec("accept_pub", 2, 3, 0, 0, 0, 0);
        tick(0, 0, 1, 0);
        check("accept_pub_drop", valid, 0);

        // Reset in the middle of a burst discards it
        send(3, 2, 1);
        tick(0, 0, 1, 1);
        check("midrst_valid", valid, 0);
        repeat (G + 2) tick(0, 0, 1, 0);
        check("midrst_nothing", valid, 0);
        send(4, 2, 1);
        wait_rec(1, w);
        expect_rec("after_rst", 4, 0, 0, 0, 0, 0);
        tick(0, 0, 1, 0);

        // Randomized traffic against the model
        dens = 0;
        for (int i = 0; i < 4000; i++) begin
            if (i % 64 == 0) dens = $urandom_range(0, 3);
            p  = (dens == 0) ? 0 : (dens == 1) ? 10 : 90;
            s  = !stop && ($urandom_range(0, 99) < p);
            t  = ($urandom_range(0, 99) < 2);
            r  = ($urandom_range(0, 99) < 70);
            rs = ($urandom_range(0, 999) < 2);
            tick(s, t, r, rs);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_stop_count_capture
